// File: rtl/booth_r4_seq_mult_if.sv
// ---------------------------------------------------------------------------
// booth_r4_seq_mult_if
//
// Purpose:
//   Bundles the operand and result handshakes of the iterative radix-4 Booth
//   multiplier so the source and the sink see one coherent bus.
//
// Signals:
//   in_valid   source -> mult   operands a, b, is_signed are valid
//   in_ready   mult -> source   multiplier can accept operands
//   a          source -> mult   multiplicand, WIDTH bits
//   b          source -> mult   multiplier (Booth-recoded), WIDTH bits
//   is_signed  source -> mult   1 = two's-complement operands, 0 = unsigned
//   out_valid  mult -> sink     p holds a completed product
//   out_ready  sink -> mult     sink accepts p
//   p          mult -> sink     registered product, 2*WIDTH bits
//
// Modports:
//   master  the operand source / result sink side
//   slave   the multiplier itself
// ---------------------------------------------------------------------------
interface booth_r4_seq_mult_if #(
    parameter int WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   is_signed;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     p;

    modport master (
        output in_valid,
        output a,
        output b,
        output is_signed,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  p
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  is_signed,
        input  out_ready,
        output in_ready,
        output out_valid,
        output p
    );
endinterface

// File: rtl/booth_r4_seq_mult.sv
// ---------------------------------------------------------------------------
// booth_r4_seq_mult
//
// Purpose:
//   Iterative radix-4 (modified Booth) multiplier with a generic operand
//   width and a run-time signed/unsigned mode. One Booth digit is retired
//   per clock, so a product takes WIDTH/2+1 clocks after the operands are
//   accepted. Successor of the free-running fixed 8-bit Booth block.
//
// Parameters:
//   WIDTH  operand width in bits; must be even and >= 4
//   OEB_W  width of the pad output-enable bus
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-high reset
//   bus     slave side of booth_r4_seq_mult_if (operand and result
//           valid/ready handshakes, operands, mode, registered product)
//   io_oeb  pad output-enable bus, constant all-zero (pads are outputs)
//
// Operation:
//   IDLE  in_ready=1; an in_valid accept extends and captures the operands
//         and clears the accumulator.
//   CALC  one Booth digit per clock is added into the accumulator; on the
//         last digit the product register is loaded.
//   DONE  out_valid=1 with p stable until out_ready, then back to IDLE.
// ---------------------------------------------------------------------------
module booth_r4_seq_mult #(
    parameter int WIDTH = 8,
    parameter int OEB_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    booth_r4_seq_mult_if.slave bus,
    output logic [OEB_W-1:0]   io_oeb
);

    // Operands are carried two bits wider than WIDTH so that an unsigned
    // all-ones value still looks positive to the signed Booth recoding.
    localparam int E    = WIDTH + 2;
    localparam int N    = WIDTH / 2 + 1;
    localparam int AW   = 2 * E;
    localparam int CW   = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [AW-1:0]       acc;
    logic [AW-1:0]       a_sh;
    logic [E:0]          b_sr;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [2*WIDTH-1:0]  p_q;

    logic [E-1:0]        a_ext;
    logic [E-1:0]        b_ext;
    logic [AW-1:0]       pp;
    logic [AW-1:0]       acc_next;

    assign io_oeb        = '0;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.p         = p_q;

    // Operand extension happens at accept time, so the mode is effectively
    // captured together with the operands and later changes of is_signed
    // cannot disturb a running computation.
    always_comb begin
        a_ext = {2'b00, bus.a};
        b_ext = {2'b00, bus.b};
        if (bus.is_signed) begin
            a_ext = {{2{bus.a[WIDTH-1]}}, bus.a};
            b_ext = {{2{bus.b[WIDTH-1]}}, bus.b};
        end
    end

    // Partial product for the current digit. a_sh already holds the
    // multiplicand shifted to the digit's weight and b_sr[2:0] is the
    // current Booth triplet, so no variable indexing is needed.
    always_comb begin
        pp = '0;
        case (b_sr[2:0])
            3'b001, 3'b010: pp = a_sh;
            3'b011:         pp = a_sh << 1;
            3'b100:         pp = ~(a_sh << 1) + AW'(1);
            3'b101, 3'b110: pp = ~a_sh + AW'(1);
            default:        pp = '0;
        endcase
        acc_next = acc + pp;
    end

    // Control FSM and datapath registers. The multiplicand moves left and
    // the multiplier right by one digit per clock; the implicit b_ext[-1]
    // zero lives in b_sr[0] at accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            p_q         <= '0;
            cnt         <= '0;
            acc         <= '0;
            a_sh        <= '0;
            b_sr        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh       <= {{(AW-E){a_ext[E-1]}}, a_ext};
                        b_sr       <= {b_ext, 1'b0};
                        acc        <= '0;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    acc  <= acc_next;
                    a_sh <= a_sh << 2;
                    b_sr <= {2'b00, b_sr[E:2]};
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        p_q         <= acc_next[2*WIDTH-1:0];
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// ---------------------------------------------------------------------------
// tb_booth_r4_seq_mult
//
// Purpose:
//   Self-checking bench for booth_r4_seq_mult with a WIDTH=8 and a WIDTH=16
//   instance sharing one clock and reset. Expected products come from plain
//   integer multiplication of the extended operands.
// ---------------------------------------------------------------------------
module tb_booth_r4_seq_mult;

    logic        clk;
    logic        reset;
    logic [15:0] oeb8;
    logic [15:0] oeb16;

    int checks;
    int passed;

    booth_r4_seq_mult_if #(.WIDTH(8))  bus8 ();
    booth_r4_seq_mult_if #(.WIDTH(16)) bus16 ();

    booth_r4_seq_mult #(.WIDTH(8), .OEB_W(16)) dut8 (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus8),
        .io_oeb (oeb8)
    );

    booth_r4_seq_mult #(.WIDTH(16), .OEB_W(16)) dut16 (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus16),
        .io_oeb (oeb16)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference product: extend each operand according to the mode, multiply
    // as integers and keep the low 2*w bits.
    function automatic logic [31:0] refModel(input int w, input logic [15:0] av,
                                             input logic [15:0] bv, input logic sgn);
        longint x;
        longint y;
        longint prod;
        if (w == 8) begin
            x = sgn ? longint'($signed(av[7:0])) : longint'(av[7:0]);
            y = sgn ? longint'($signed(bv[7:0])) : longint'(bv[7:0]);
        end else begin
            x = sgn ? longint'($signed(av)) : longint'(av);
            y = sgn ? longint'($signed(bv)) : longint'(bv);
        end
        prod = x * y;
        if (w == 8) return {16'h0000, prod[15:0]};
        return prod[31:0];
    endfunction

    function automatic logic getValid(input int w);
        return (w == 8) ? bus8.out_valid : bus16.out_valid;
    endfunction

    function automatic logic getReady(input int w);
        return (w == 8) ? bus8.in_ready : bus16.in_ready;
    endfunction

    function automatic logic [31:0] getP(input int w);
        return (w == 8) ? {16'h0000, bus8.p} : bus16.p;
    endfunction

    task automatic setIn(input int w, input logic v, input logic [15:0] av,
                         input logic [15:0] bv, input logic sgn);
        if (w == 8) begin
            bus8.in_valid  = v;
            bus8.a         = av[7:0];
            bus8.b         = bv[7:0];
            bus8.is_signed = sgn;
        end else begin
            bus16.in_valid  = v;
            bus16.a         = av;
            bus16.b         = bv;
            bus16.is_signed = sgn;
        end
    endtask

    task automatic setOutReady(input int w, input logic r);
        if (w == 8) bus8.out_ready = r;
        else        bus16.out_ready = r;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Presents one operand pair, lets it be accepted, scrambles the inputs
    // and counts clock edges until out_valid rises (bounded).
    task automatic applyStimulus(input int w, input logic [15:0] av,
                                 input logic [15:0] bv, input logic sgn,
                                 output int lat);
        @(negedge clk);
        setIn(w, 1'b1, av, bv, sgn);
        @(negedge clk);
        setIn(w, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
        lat = 0;
        while (lat < 40 && getValid(w) !== 1'b1) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Full transaction: product, latency, and the output handshake.
    task automatic runOp(input int w, input logic [15:0] av, input logic [15:0] bv,
                         input logic sgn, input logic [31:0] exp, input string tag);
        int lat;
        checkOutput({tag, "_ready_before"}, {31'd0, getReady(w)}, 32'd1);
        applyStimulus(w, av, bv, sgn, lat);
        checkOutput({tag, "_latency"}, 32'(lat), (w == 8) ? 32'd5 : 32'd9);
        checkOutput({tag, "_p"}, getP(w), exp);
        setOutReady(w, 1'b1);
        @(negedge clk);
        setOutReady(w, 1'b0);
        checkOutput({tag, "_release"}, {30'd0, getValid(w), getReady(w)}, 32'd1);
    endtask

    initial begin
        int lat;
        int saw_valid;
        logic [15:0] av;
        logic [15:0] bv;
        logic        sgn;
        logic [31:0] held_p;

        checks = 0;
        passed = 0;
        reset  = 1'b1;
        setIn(8, 1'b0, 16'h0, 16'h0, 1'b0);
        setIn(16, 1'b0, 16'h0, 16'h0, 1'b0);
        setOutReady(8, 1'b0);
        setOutReady(16, 1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst8_hs", {30'd0, getValid(8), getReady(8)}, 32'd1);
        checkOutput("rst8_p", getP(8), 32'h0);
        checkOutput("rst16_hs", {30'd0, getValid(16), getReady(16)}, 32'd1);
        checkOutput("rst16_p", getP(16), 32'h0);
        reset = 1'b0;
        $display("[TB] reset released");

        // Directed edge operands, WIDTH=8
        runOp(8, 16'h0080, 16'h0080, 1'b1, 32'h4000, "w8_neg128_sq");
        runOp(8, 16'h00FF, 16'h00FF, 1'b0, 32'hFE01, "w8_ff_ff_u");
        runOp(8, 16'h00FF, 16'h00FF, 1'b1, 32'h0001, "w8_ff_ff_s");
        runOp(8, 16'h00FF, 16'h0001, 1'b1, 32'hFFFF, "w8_m1_1_s");
        runOp(8, 16'h0000, 16'h005A, 1'b1, 32'h0000, "w8_zero");

        // Directed edge operands, WIDTH=16
        runOp(16, 16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF0001, "w16_max_sq_s");
        runOp(16, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "w16_ff_ff_u");
        runOp(16, 16'h8000, 16'h8000, 1'b1, 32'h40000000, "w16_min_sq_s");
        checkOutput("oeb_mid", {oeb8, oeb16}, 32'h0);

        // Backpressure: hold out_ready low and try to push a new operand
        applyStimulus(8, 16'h0012, 16'h0034, 1'b1, lat);
        checkOutput("bp_latency", 32'(lat), 32'd5);
        checkOutput("bp_p", getP(8), 32'h03A8);
        setIn(8, 1'b1, 16'h0077, 16'h0066, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_hold_hs", {30'd0, getValid(8), getReady(8)}, 32'd2);
            checkOutput("bp_hold_p", getP(8), 32'h03A8);
        end
        setIn(8, 1'b0, 16'h0, 16'h0, 1'b0);
        setOutReady(8, 1'b1);
        @(negedge clk);
        setOutReady(8, 1'b0);
        checkOutput("bp_release", {30'd0, getValid(8), getReady(8)}, 32'd1);
        saw_valid = 0;
        repeat (8) begin
            @(negedge clk);
            if (getValid(8) === 1'b1) saw_valid++;
        end
        checkOutput("bp_no_extra", 32'(saw_valid), 32'd0);
        checkOutput("bp_p_kept", getP(8), 32'h03A8);

        // Reset in the middle of a computation (counter at 2)
        @(negedge clk);
        setIn(8, 1'b1, 16'h0055, 16'h0033, 1'b1);
        @(negedge clk);
        setIn(8, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midrst_hs", {30'd0, getValid(8), getReady(8)}, 32'd1);
        checkOutput("midrst_p", getP(8), 32'h0);
        saw_valid = 0;
        repeat (10) begin
            @(negedge clk);
            if (getValid(8) === 1'b1) saw_valid++;
        end
        checkOutput("midrst_no_done", 32'(saw_valid), 32'd0);

        // Randomized vectors against the reference model
        for (int i = 0; i < 1000; i++) begin
            av  = 16'($urandom);
            bv  = 16'($urandom);
            sgn = 1'(i);
            runOp(16, av, bv, sgn, refModel(16, av, bv, sgn), "w16_rand");
        end
        for (int i = 0; i < 200; i++) begin
            av  = {8'h00, 8'($urandom)};
            bv  = {8'h00, 8'($urandom)};
            sgn = 1'($urandom);
            runOp(8, av, bv, sgn, refModel(8, av, bv, sgn), "w8_rand");
        end

        // Product survives idle time untouched
        held_p = getP(16);
        repeat (5) @(negedge clk);
        checkOutput("w16_p_hold_idle", getP(16), held_p);
        checkOutput("oeb_end", {oeb8, oeb16}, 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/booth_r4_seq_mult.md
Name: booth_r4_seq_mult

Overview:
- Parametrised, iterative radix-4 (modified Booth) multiplier. It is the successor to the free-running fixed 8-bit Booth block.
- Operand width is generic, with a run-time signed/unsigned mode and valid/ready handshakes on input and output.
- One Booth digit is retired per clock, which trades latency for area.
- Sits between an operand source (test counter or wishbone regs) and a result sink/IO pads. It drives a pad output-enable bus like its predecessor.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 4.
- OEB_W, 16, width of the io_oeb output-enable bus.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands a, b, is_signed are valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier (Booth-recoded)
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned
- out_valid  output  1  p holds a completed product
- out_ready  input  1  sink accepts p
- p  output  2*WIDTH  product, registered
- io_oeb  output  OEB_W  constant all-zero (pads driven as outputs)

Behaviour:
- Reset, one clock and synchronous active-high as decided: state=IDLE, in_ready=1, out_valid=0, p=0, counter=0, accumulator=0. io_oeb=0 always.
- Internal operand width E=WIDTH+2.
  - a and b are sign-extended when is_signed=1, otherwise zero-extended.
  - is_signed is latched at accept.
- Digit count N=WIDTH/2+1. For WIDTH=8, N=5.
- Accumulator is 2*E bits. Final p = accumulator[2*WIDTH-1:0], which is exact in both modes.
- FSM states:
  - IDLE: in_ready=1. When in_valid&&in_ready, latch operands and mode, clear accumulator, cnt=0, go to CALC.
  - CALC: in_ready=0, out_valid=0.
    - Each edge: form digit d from triplet {b_ext[2cnt+1], b_ext[2cnt], b_ext[2cnt-1]}, with b_ext[-1]=0.
    - Mapping: 000/111→0, 001/010→+1, 011→+2, 100→-2, 101/110→-1.
    - Add d*a_ext<<(2cnt), sign-extended to 2*E, to accumulator. Use two's-complement negate for -1/-2.
    - cnt++. On the edge where cnt==N-1, the final partial product is added, p is loaded and the state goes to DONE.
  - DONE: out_valid=1, p stable, in_ready=0. When out_ready=1, go to IDLE; out_valid drops the next cycle.
- Latency: out_valid rises exactly N clock edges after the accepting edge. Minimum initiation interval is N+2 cycles.
- There is no overlap of accept and complete (in_ready is low in DONE). One bubble cycle after the output handshake is required.
- in_valid is ignored outside IDLE. Operand inputs may change freely after accept.
- Backpressure: out_ready held low keeps DONE indefinitely, with p and out_valid stable.
- p holds its last value through IDLE/CALC until overwritten at the next completion. It is cleared only by reset.
- Reset asserted in any state (including mid-CALC) has priority over all handshakes. The next cycle is IDLE with outputs at reset values, and the partial result is discarded with no out_valid pulse.
- Edge operands must be exact:
  - WIDTH-bit most-negative values, e.g. -128 with -128 for WIDTH=8.
  - All-ones unsigned operands.
  - Zero.

Test Plan:
- WIDTH=8, signed, a=0x80(-128), b=0x80 → out_valid 5 edges after accept, p=0x4000.
- WIDTH=8, unsigned, a=0xFF, b=0xFF → p=0xFE01. Same operands signed (-1*-1) → p=0x0001.
- WIDTH=8, signed, a=0xFF(-1), b=0x01 → p=0xFFFF. Then a=0x00, b=0x5A → p=0x0000.
- Backpressure: out_ready=0 for 10 cycles after completion → out_valid/p stable, in_ready=0, and a new in_valid is ignored. out_ready=1 → IDLE next cycle.
- Reset asserted at cnt=2 of a computation → next cycle IDLE, in_ready=1, out_valid=0, p=0. No completion is emitted.
- WIDTH=16 instance: signed 0x7FFF*0x7FFF → p=0x3FFF0001 after 9 edges. Unsigned 0xFFFF*0xFFFF → 0xFFFE0001. Random 1000 vectors in both modes are checked against a reference model; io_oeb is 0 throughout.
